c2tosm_pipe: RTL and testbench
==============================

Name: c2tosm_pipe

Overview:
- Converts a pair of W-bit two's-complement operands (x, y) into sign-magnitude form.
- Sits on the output side of the arithmetic datapath. Results computed in two's complement are returned to the sign-magnitude bus format used by the operand inputs.
- Two-stage valid/ready pipeline, full throughput (one pair per cycle).
- Flags and counts the unrepresentable value -2^(W-1).

Parameters:
- W, 8, operand width in bits (sign + W-1 magnitude bits); legal range 2..32.
- CW, 8, width of the saturation-event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  x_c2/y_c2 pair presented.
- in_ready  out  1  block can accept the pair this cycle.
- x_c2  in  W  operand x, two's complement.
- y_c2  in  W  operand y, two's complement.
- out_valid  out  1  x_sm/y_sm pair valid.
- out_ready  in  1  downstream accepts the pair this cycle.
- x_sm  out  W  operand x, sign-magnitude.
- y_sm  out  W  operand y, sign-magnitude.
- x_sat  out  1  x was -2^(W-1) and has been saturated (qualified by out_valid).
- y_sat  out  1  same, for y.
- sat_cnt  out  CW  count of saturation events since reset or clear.
- cnt_clr  in  1  synchronous clear of sat_cnt.

Behaviour:
- Reset (rst high, asynchronous): both stage valids = 0, out_valid = 0, x_sm = y_sm = 0, x_sat = y_sat = 0, sat_cnt = 0. in_ready = 1 during and after reset.
- Rst asserted mid-transfer discards all in-flight data. No output handshake completes for the discarded data.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage S1 captures the accepted raw operands. It computes per operand:
  - sign = bit W-1.
  - neg = (~v)+1, truncated to W bits.
  - sat = (v == 1 followed by W-1 zeros).
- Stage S2 registers the outputs, per operand:
  - sign = 0: out = v unchanged, sat = 0.
  - sign = 1 and sat = 0: out = {1, neg[W-2:0]}.
  - sign = 1 and sat = 1: out = {1, all ones in W-1 bits}, i.e. -(2^(W-1)-1), and sat = 1.
- Negative zero (1 followed by zeros) is never produced.
- Latency: a pair accepted in cycle N appears with out_valid = 1 in cycle N+2 if out_ready was not stalling.
- Flow control:
  - s2_load = s1_valid && (!out_valid || out_ready).
  - s1_load = in_valid && in_ready.
  - in_ready = !s1_valid || s2_load. This is combinational from out_ready, with no bubble at full throughput.
  - S1 and S2 hold their contents while stalled.
  - x_sm, y_sm, x_sat and y_sat stay stable while out_valid && !out_ready.
  - out_valid falls only after a transfer with no S1 data pending.
- Simultaneous S1 load and S2 load in the same cycle: S2 takes the old S1 content and S1 takes the new input (pass-through pipelining).
- sat_cnt:
  - Increments in the cycle S2 loads, by x_sat + y_sat, so 0, 1 or 2.
  - Saturates at 2^CW-1 with no wrap-around.
  - cnt_clr has priority over increment in the same cycle: result 0.
  - Counts on S2 load, not on output handshake, so stalls do not double count.
- in_valid deasserted with in_ready low is permitted. Upstream is not required to hold data; the block does not rely on it.

Test Plan:
- Reset, then out_ready = 1. Send x_c2 = 0x05, y_c2 = 0xFB (-5) → 2 cycles later x_sm = 0x05, y_sm = 0x85, sats = 0, sat_cnt = 0.
- Send x_c2 = 0x80, y_c2 = 0x00 → x_sm = 0xFF, x_sat = 1, y_sm = 0x00, y_sat = 0, sat_cnt = 1. Then send 0x80/0x80 → sat_cnt = 3.
- Stream 16 back-to-back pairs with out_ready = 1 → 16 outputs on consecutive cycles in order, in_ready constantly 1.
- Hold out_ready = 0 with 4 pairs offered → exactly 2 accepted, then in_ready = 0 and outputs stable. Release out_ready → remaining pairs delivered in order, with no loss or duplication.
- Set CW = 2 and send three 0x80/0x80 pairs → sat_cnt stops at 3. Pulse cnt_clr in the same cycle as a saturating S2 load → sat_cnt = 0.
- Assert rst while S1 and S2 are full and out_ready = 0 → out_valid = 0 immediately, all outputs 0, and the next accepted pair emerges 2 cycles after acceptance.

Source files
------------

// File: rtl/c2tosm_pipe.sv
// c2tosm_pipe: two-stage two's-complement to sign-magnitude converter for an
// (x, y) operand pair, with saturation flags and a saturating event counter.
module c2tosm_pipe #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x_c2,
  input  logic [W-1:0]  y_c2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  x_sm,
  output logic [W-1:0]  y_sm,
  output logic          x_sat,
  output logic          y_sat,
  output logic [CW-1:0] sat_cnt,
  input  logic          cnt_clr
);

  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXN = {1'b1, {(W-1){1'b1}}};
  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [CW:0]  CMAX = {1'b0, {CW{1'b1}}};

  logic          r_s1_valid;
  logic [W-1:0]  r_s1_x;
  logic [W-1:0]  r_s1_y;
  logic          r_out_valid;
  logic [W-1:0]  r_x_sm;
  logic [W-1:0]  r_y_sm;
  logic          r_x_sat;
  logic          r_y_sat;
  logic [CW-1:0] r_cnt;

  logic          w_s1_load;
  logic          w_s2_load;
  logic [W-1:0]  w_x_neg;
  logic [W-1:0]  w_y_neg;
  logic          w_x_sat;
  logic          w_y_sat;
  logic [W-1:0]  w_x_sm;
  logic [W-1:0]  w_y_sm;
  logic [CW:0]   w_cnt_sum;
  logic [CW-1:0] w_cnt_next;

  assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_s1_load = in_valid && in_ready;

  assign w_x_neg = ~r_s1_x + ONE;
  assign w_y_neg = ~r_s1_y + ONE;
  assign w_x_sat = (r_s1_x == MINV);
  assign w_y_sat = (r_s1_y == MINV);

  // -2^(W-1) has no magnitude encoding; clamp to the largest negative one
  always_comb begin
    w_x_sm = r_s1_x;
    if (r_s1_x[W-1]) begin
      w_x_sm = w_x_sat ? MAXN : {1'b1, w_x_neg[W-2:0]};
    end
  end

  always_comb begin
    w_y_sm = r_s1_y;
    if (r_s1_y[W-1]) begin
      w_y_sm = w_y_sat ? MAXN : {1'b1, w_y_neg[W-2:0]};
    end
  end

  assign w_cnt_sum = {1'b0, r_cnt} + (CW+1)'(w_x_sat)
                   + (CW+1)'(w_y_sat);
  assign w_cnt_next = (w_cnt_sum > CMAX) ? CMAX[CW-1:0]
                                         : w_cnt_sum[CW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_out_valid <= 1'b0;
      r_x_sm      <= '0;
      r_y_sm      <= '0;
      r_x_sat     <= 1'b0;
      r_y_sat     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_x <= x_c2;
        r_s1_y <= y_c2;
      end
      if (w_s1_load) begin
        r_s1_valid <= 1'b1;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_load) begin
        r_out_valid <= 1'b1;
        r_x_sm      <= w_x_sm;
        r_y_sm      <= w_y_sm;
        r_x_sat     <= w_x_sat;
        r_y_sat     <= w_y_sat;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      // counted on S2 load so a stalled output is never counted twice
      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_s2_load) begin
        r_cnt <= w_cnt_next;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign x_sm      = r_x_sm;
  assign y_sm      = r_y_sm;
  assign x_sat     = r_x_sat;
  assign y_sat     = r_y_sat;
  assign sat_cnt   = r_cnt;

endmodule

// File: tb/tb_c2tosm_pipe.sv
// Scoreboard bench for c2tosm_pipe: random and directed traffic checked
// against an arithmetic sign-magnitude model; a CW=2 copy checks the counter.
module tb_c2tosm_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x_c2;
  logic [7:0] y_c2;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] x_sm;
  logic [7:0] y_sm;
  logic       x_sat;
  logic       y_sat;
  logic [7:0] sat_cnt;
  logic       cnt_clr;

  logic       s_rst;
  logic       s_in_valid;
  logic       s_in_ready;
  logic [7:0] s_x_c2;
  logic [7:0] s_y_c2;
  logic       s_out_valid;
  logic       s_out_ready;
  logic [7:0] s_x_sm;
  logic [7:0] s_y_sm;
  logic       s_x_sat;
  logic       s_y_sat;
  logic [1:0] s_sat_cnt;
  logic       s_cnt_clr;

  always #5 clk = ~clk;

  c2tosm_pipe #(.W(8), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_c2(x_c2), .y_c2(y_c2),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_sm(x_sm), .y_sm(y_sm),
    .x_sat(x_sat), .y_sat(y_sat),
    .sat_cnt(sat_cnt), .cnt_clr(cnt_clr)
  );

  c2tosm_pipe #(.W(8), .CW(2)) dut_s (
    .clk(clk), .rst(s_rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .x_c2(s_x_c2), .y_c2(s_y_c2),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .x_sm(s_x_sm), .y_sm(s_y_sm),
    .x_sat(s_x_sat), .y_sat(s_y_sat),
    .sat_cnt(s_sat_cnt), .cnt_clr(s_cnt_clr)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       xs;
    logic       ys;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   cum;
  int   vectors = 0;
  int   miscompares = 0;
  int   n_out = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // returns {sat, sign-magnitude} from plain integer arithmetic
  function automatic logic [8:0] model(input logic [7:0] v);
    int s;
    s = int'($signed(v));
    if (s >= 0) return {1'b0, v};
    if (s == -128) return {1'b1, 8'hFF};
    return {1'b0, 8'(128 - s)};
  endfunction

  always @(negedge clk) begin : push_p
    logic [8:0] mx;
    logic [8:0] my;
    if (rst) begin
      cum = 0;
      q.delete();
    end else if (in_valid && in_ready) begin
      mx = model(x_c2);
      my = model(y_c2);
      cum = cum + int'(mx[8]) + int'(my[8]);
      if (cum > 255) cum = 255;
      q.push_back('{x: mx[7:0], y: my[7:0], xs: mx[8], ys: my[8],
                    cnt: 8'(cum)});
    end
  end

  always @(negedge clk) begin : mon_p
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_out: got x_sm 0x%0h with none expected",
                 x_sm);
      end else begin
        e = q.pop_front();
        chk("x_sm", x_sm, e.x);
        chk("y_sm", y_sm, e.y);
        chk("x_sat", x_sat, e.xs);
        chk("y_sat", y_sat, e.ys);
        chk("sat_cnt", sat_cnt, e.cnt);
      end
      n_out++;
    end
  end

  task automatic send_lat(input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] ex, input logic [7:0] ey,
                          input logic exs, input logic eys,
                          input logic [7:0] ec);
    @(posedge clk); #1;
    in_valid = 1'b1;
    x_c2 = x;
    y_c2 = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat2_valid", out_valid, 1);
    chk("tp_x_sm", x_sm, ex);
    chk("tp_y_sm", y_sm, ey);
    chk("tp_x_sat", x_sat, exs);
    chk("tp_y_sat", y_sat, eys);
    chk("tp_cnt", sat_cnt, ec);
  endtask

  task automatic drain(input string nm);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk(nm, q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] sx[4];
    logic [7:0] sy[4];
    logic [7:0] hx;
    logic [7:0] hy;
    int k;
    int n0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    x_c2 = '0; y_c2 = '0;
    s_rst = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b0;
    s_cnt_clr = 1'b0; s_x_c2 = '0; s_y_c2 = '0;
    hx = '0; hy = '0;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x_sm", x_sm, 0);
    chk("rst_y_sm", y_sm, 0);
    chk("rst_cnt", sat_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    send_lat(8'h05, 8'hFB, 8'h05, 8'h85, 0, 0, 8'd0);
    send_lat(8'h80, 8'h00, 8'hFF, 8'h00, 1, 0, 8'd1);
    send_lat(8'h80, 8'h80, 8'hFF, 8'hFF, 1, 1, 8'd3);
    drain("drain_tp");

    n0 = n_out;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      x_c2 = 8'($urandom);
      y_c2 = 8'($urandom);
      @(negedge clk);
      chk("stream_rdy", in_ready, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    chk("stream_count", n_out - n0, 16);

    for (int i = 0; i < 4; i++) begin
      sx[i] = 8'($urandom);
      sy[i] = 8'($urandom);
    end
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1;
      x_c2 = sx[k];
      y_c2 = sy[k];
      @(negedge clk);
      if (i == 2) begin
        hx = x_sm;
        hy = y_sm;
      end
      if (i >= 3) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_x", x_sm, hx);
        chk("stall_y", y_sm, hy);
      end
      if (in_ready) k++;
    end
    chk("stall_accepts", k, 2);
    chk("stall_rdy", in_ready, 0);
    for (int i = 0; i < 10 && k < 4; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      x_c2 = sx[k];
      y_c2 = sy[k];
      @(negedge clk);
      if (in_ready) k++;
    end
    chk("release_accepts", k, 4);
    drain("drain_stall");

    for (int i = 0; i < 700; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      x_c2 = ($urandom_range(3) == 0) ? 8'h80 : 8'($urandom);
      y_c2 = ($urandom_range(3) == 0) ? 8'h80 : 8'($urandom);
    end
    drain("drain_rand");

    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    x_c2 = 8'h80;
    y_c2 = 8'h80;
    @(posedge clk); #1;
    x_c2 = 8'h80;
    y_c2 = 8'h80;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_x", x_sm, 0);
    chk("mid_rst_y", y_sm, 0);
    chk("mid_rst_xsat", x_sat, 0);
    chk("mid_rst_cnt", sat_cnt, 0);
    chk("mid_rst_rdy", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send_lat(8'h80, 8'h01, 8'hFF, 8'h01, 1, 0, 8'd1);
    drain("drain_rst");

    @(posedge clk); #1;
    s_rst = 1'b0;
    s_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      s_in_valid = 1'b1;
      s_x_c2 = 8'h80;
      s_y_c2 = 8'h80;
      @(negedge clk);
      if (i == 2) chk("cw2_cnt_a", s_sat_cnt, 2);
    end
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    @(negedge clk);
    chk("cw2_cnt_b", s_sat_cnt, 3);
    @(negedge clk);
    chk("cw2_cnt_hold", s_sat_cnt, 3);
    @(posedge clk); #1;
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    s_cnt_clr = 1'b1;
    @(posedge clk); #1;
    s_cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt", s_sat_cnt, 0);
    chk("clr_valid", s_out_valid, 1);
    chk("clr_xsat", s_x_sat, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
